muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
// - Iterative RV32M multiply/divide unit: sequences a shared 32-bit radix-2 add/shift datapath
//   over 32 iterations, then a sign-fixup cycle.
// - Sits beside the main ALU in EX. The controller routes R-type ops with Funct7=7'b0000001 here;
//   the core stalls while in_ready is low or out_valid is pending.
// PARAMETERS
// - XLEN      32  operand/result width (only 32 supported; other values are an elaboration error)
// - ITER_CNTW 6   width of the iteration counter (must hold XLEN)
// PORTS
// - clk         in   1     core clock, rising edge
// - rst_n       in   1     asynchronous, active-low reset
// - in_valid    in   1     request valid
// - in_ready    out  1     unit can accept a request (high only in IDLE)
// - funct3      in   3     RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - op_a        in   XLEN  rs1 value
// - op_b        in   XLEN  rs2 value
// - flush       in   1     kill any in-flight or pending operation
// - out_valid   out  1     result valid
// - out_ready   in   1     consumer takes the result
// - result      out  XLEN  result
// BEHAVIOUR
// - Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all operand/acc regs=0.
// - Accept: in_valid & in_ready at edge N latches funct3, |op_a|, |op_b| (magnitude only for signed operands),
//   the result-sign flag and the special-case flags.
// - FSM:
//   - IDLE -> CALC on accept.
//   - CALC: 32 iterations, counter 0..31; CALC -> FIX when counter==31.
//   - FIX: one cycle; negate if needed, select hi/lo/quotient/remainder; FIX -> DONE.
//   - DONE: out_valid=1; DONE -> IDLE on out_ready.
// - Latency: out_valid rises after edge N+34 (32 CALC + 1 FIX + DONE registration). Throughput is one op per 34+ cycles.
// - Multiply: 64-bit unsigned product of the magnitudes; negated in FIX when the sign flag is set.
//   - MUL returns [31:0]; MULH, MULHSU and MULHU return [63:32].
//   - MULHSU treats op_a as signed and op_b as unsigned.
// - Divide: restoring division of the magnitudes.
//   - Quotient sign = sign(a) xor sign(b).
//   - Remainder sign = sign(a).
// - Special cases, forced in FIX regardless of the datapath value:
//   - divisor==0: DIV/DIVU -> 32'hFFFF_FFFF; REM/REMU -> op_a.
//   - DIV with a=32'h8000_0000, b=-1 -> 32'h8000_0000; REM in that case -> 0.
// - Output handshake: result and out_valid are held stable while out_valid & !out_ready.
//   result is unchanged after the transfer until the next FIX.
// - in_ready is combinational from state (IDLE). A request is not accepted in the same cycle that DONE drains.
// - flush is synchronous and has priority over everything:
//   - next state IDLE, out_valid=0, counter cleared;
//   - a request in the same cycle as flush is not accepted.
// - Asynchronous reset mid-operation abandons it; no partial result is visible.
// - Undefined funct3 is not possible (3 bits fully decoded).
// CONFIGURATION
// - MULDIV_EARLY_OUT_EN defined: at accept, ops with divisor==0, signed overflow, or either multiply operand==0
//   go IDLE -> FIX directly. out_valid rises after edge N+2.
// - MULDIV_EARLY_OUT_EN undefined: every op takes the full 34-cycle path. Results are identical in both builds.
// STRUCTURE
// - Shared package muldiv_pkg:
//   - XLEN;
//   - typedef enum logic [2:0] muldiv_op_e (funct3 encodings above);
//   - typedef enum logic [1:0] muldiv_state_e {IDLE, CALC, FIX, DONE};
//   - the RV32M funct7 constant 7'b0000001.
// - One sub-module, muldiv_iter_step: combinational single iteration.
//   - Multiply: conditional add + shift.
//   - Divide: trial subtract + shift.
//   - Instantiated once; the sequencer owns all registers.
// TESTING
// - MUL a=7, b=-3 -> result 32'hFFFF_FFEB; out_valid exactly 34 cycles after accept (no EARLY_OUT).
// - MULH a=b=32'h8000_0000 -> 32'h4000_0000.
// - MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE.
// - MULHSU a=-1, b=2 -> 32'hFFFF_FFFF.
// - DIV a=-7, b=2 -> 32'hFFFF_FFFD; REM a=-7, b=2 -> 32'hFFFF_FFFF; DIVU a=100, b=7 -> 14.
// - Divide by zero: DIV a=5, b=0 -> 32'hFFFF_FFFF; REMU a=5, b=0 -> 5.
//   - Overflow: DIV 32'h8000_0000 / -1 -> 32'h8000_0000; REM -> 0.
//   - EARLY_OUT build: out_valid 2 cycles after accept.
// - Backpressure: hold out_ready=0 for 10 cycles in DONE.
//   - result and out_valid stay stable; in_ready stays 0.
//   - A new in_valid is only accepted in IDLE, the cycle after the out_ready handshake.
// - Flush and reset:
//   - flush at CALC counter=15 -> IDLE next cycle, in_ready=1, no out_valid.
//   - rst_n low mid-CALC -> all outputs at reset values immediately.
//   - The next op after either completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   XLEN             operand/result width
//   FUNCT7_MULDIV    RV32M funct7 value routed to this unit by the controller
//   muldiv_op_e      funct3 encodings of the eight RV32M operations
//   muldiv_state_e   sequencer states
// Helper functions classify an operation by its funct3 code.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Divide and remainder ops all have funct3[2] set.
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // MUL is treated as signed: its low word is identical either way.
    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the core (master) and the multiply/divide
// unit (slave).
//   in_valid/in_ready    request handshake; funct3, op_a, op_b ride with it
//   flush                kill any in-flight or pending operation
//   out_valid/out_ready  response handshake; result rides with it
// -----------------------------------------------------------------------------
interface muldiv_if;
    import muldiv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, funct3, op_a, op_b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/muldiv_iter_step.sv
// -----------------------------------------------------------------------------
// muldiv_iter_step
// One combinational radix-2 iteration over the {acc, mq} register pair.
//   is_div     1: restoring-divide step, 0: shift-add multiply step
//   acc, mq    current high/low working words
//   opnd       multiplicand or divisor magnitude
//   acc_next   next high word
//   mq_next    next low word
// Multiply: {acc, mq} = ({acc + (mq[0] ? opnd : 0)}, mq) >> 1
// Divide:   shift {acc, mq} left by one, subtract opnd from the top if it fits,
//           and shift the quotient bit into mq[0].
// -----------------------------------------------------------------------------
module muldiv_iter_step import muldiv_pkg::*; (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] mq,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] mq_next
);

    logic [XLEN:0]   sum;      // carry-extended partial-product add
    logic [XLEN:0]   shifted;  // partial remainder after the left shift
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        // NOTE: every output and temporary gets a value before any branch so
        // no path leaves one unassigned and no latch is inferred.
        acc_next = acc;
        mq_next  = mq;
        sum      = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        shifted  = {acc, mq[XLEN-1]};
        fits     = shifted >= {1'b0, opnd};
        // The remainder is always below the divisor, so the low bits suffice.
        diff     = shifted[XLEN-1:0] - opnd;

        if (is_div) begin
            acc_next = fits ? diff : shifted[XLEN-1:0];
            mq_next  = {mq[XLEN-2:0], fits};
        end else begin
            acc_next = sum[XLEN:1];
            mq_next  = {sum[0], mq[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit. Operand magnitudes are latched at
// accept, 32 radix-2 iterations run through muldiv_iter_step, and one FIX
// cycle applies the sign and the RV32M special cases. The result is then
// offered on a valid/ready handshake and held until taken.
//   clk, rst_n   core clock; asynchronous active-low reset
//   bus          muldiv_if.slave: request (in_valid/in_ready, funct3, op_a,
//                op_b), flush, response (out_valid/out_ready, result)
// Parameters: XLEN (only 32), ITER_CNTW (iteration counter width, must hold XLEN)
// Build option: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed overflow and
// multiply-by-zero skip CALC and go straight to FIX. Results are identical.
// -----------------------------------------------------------------------------
module muldiv_sequencer import muldiv_pkg::*; #(
    parameter int XLEN      = 32,
    parameter int ITER_CNTW = 6
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("muldiv_sequencer: only XLEN=32 is supported");
    end
    if ((2 ** ITER_CNTW) <= XLEN) begin : g_bad_cntw
        $error("muldiv_sequencer: ITER_CNTW too narrow to hold XLEN");
    end

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_FIX  = FIX;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [ITER_CNTW-1:0] CNT_LAST = ITER_CNTW'(XLEN - 1);
    localparam logic [XLEN-1:0]      INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]           state;
    logic [ITER_CNTW-1:0] cnt;
    muldiv_op_e           op_q;
    logic [XLEN-1:0]      mag_a, mag_b, acc, mq, result_q;
    logic                 res_neg, div_zero, div_ovf, mul_zero, out_valid_q;

    // ---------------- request decode ----------------
    muldiv_op_e      op_in;
    logic            neg_a_in, neg_b_in, accept, skip_calc;
    logic            div_zero_in, div_ovf_in, mul_zero_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;

    assign op_in       = muldiv_op_e'(bus.funct3);
    assign neg_a_in    = op_signed_a(op_in) & bus.op_a[XLEN-1];
    assign neg_b_in    = op_signed_b(op_in) & bus.op_b[XLEN-1];
    assign mag_a_in    = neg_a_in ? -bus.op_a : bus.op_a;
    assign mag_b_in    = neg_b_in ? -bus.op_b : bus.op_b;
    assign div_zero_in = op_is_div(op_in) && (bus.op_b == '0);
    assign div_ovf_in  = (op_in == OP_DIV || op_in == OP_REM) &&
                         (bus.op_a == INT_MIN) && (bus.op_b == '1);
    assign mul_zero_in = !op_is_div(op_in) && (bus.op_a == '0 || bus.op_b == '0);
    // flush wins over a request arriving in the same cycle.
    assign accept      = bus.in_valid && (state == S_IDLE) && !bus.flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign skip_calc = div_zero_in | div_ovf_in | mul_zero_in;
`else
    assign skip_calc = 1'b0;
`endif

    // ---------------- datapath ----------------
    logic [XLEN-1:0] acc_next, mq_next;

    muldiv_iter_step u_step (
        .is_div   (op_is_div(op_q)),
        .acc      (acc),
        .mq       (mq),
        .opnd     (mag_b),
        .acc_next (acc_next),
        .mq_next  (mq_next)
    );

    // ---------------- sign fixup and special cases ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, a_back, fix_result;

    assign prod_fix = res_neg ? -{acc, mq} : {acc, mq};
    assign quo_fix  = res_neg ? -mq : mq;
    assign rem_fix  = res_neg ? -acc : acc;
    // For REM/REMU the sign flag is sign(a), so this rebuilds the original op_a.
    assign a_back   = res_neg ? -mag_a : mag_a;

    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL:                       fix_result = mul_zero ? '0 : prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = mul_zero ? '0 : prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = div_zero ? '1 : (div_ovf ? INT_MIN : quo_fix);
            OP_REM, OP_REMU:              fix_result = div_zero ? a_back : (div_ovf ? '0 : rem_fix);
        endcase
    end

    // ---------------- sequencer ----------------
    // NOTE: all state, including the operand and accumulator registers, is
    // cleared by reset so an abandoned operation leaves nothing observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= OP_MUL;
            mag_a       <= '0;
            mag_b       <= '0;
            acc         <= '0;
            mq          <= '0;
            result_q    <= '0;
            res_neg     <= 1'b0;
            div_zero    <= 1'b0;
            div_ovf     <= 1'b0;
            mul_zero    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state       <= S_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of the others, regardless of statement order.
            case (state)
                S_IDLE: if (accept) begin
                    op_q     <= op_in;
                    mag_a    <= mag_a_in;
                    mag_b    <= mag_b_in;
                    acc      <= '0;
                    mq       <= mag_a_in;
                    res_neg  <= op_is_rem(op_in) ? neg_a_in : (neg_a_in ^ neg_b_in);
                    div_zero <= div_zero_in;
                    div_ovf  <= div_ovf_in;
                    mul_zero <= mul_zero_in;
                    cnt      <= '0;
                    state    <= skip_calc ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    acc <= acc_next;
                    mq  <= mq_next;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    result_q <= fix_result;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    // out_valid is registered one cycle after DONE is entered.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// handshake/flush/reset sequences, and random operations compared against a
// plain-arithmetic RV32M model. Honours MULDIV_EARLY_OUT_EN for latency.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M reference computed with wide signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        logic [63:0]        up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        up = '0;
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        bit special;
        special = (f[2] && b == 0) ||
                  ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
                  (!f[2] && (a == 0 || b == 0));
        return special ? 2 : 34;
`else
        return 34;
`endif
    endfunction

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    // Issues one op from IDLE (called at posedge+1), returns result and latency.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        res = bus.result;
        drain();
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        logic [31:0] res;
        int          lat;
        do_op(f, a, b, res, lat);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    endtask

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic [31:0] r0, res;
        int          lat;
        bit          saw;

        vecs[0]  = '{"MUL 7*-3",          OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{"MULH min*min",      OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{"MULHU max*max",     OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{"MULHSU -1*2",       OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{"MULHSU min*umax",   OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[5]  = '{"DIV -7/2",          OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
        vecs[6]  = '{"REM -7%2",          OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[7]  = '{"DIV 7/-2",          OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[8]  = '{"REM 7%-2",          OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
        vecs[9]  = '{"DIVU 100/7",        OP_DIVU,   32'd100,        32'd7,         32'd14};
        vecs[10] = '{"REMU 100%7",        OP_REMU,   32'd100,        32'd7,         32'd2};
        vecs[11] = '{"DIV 5/0",           OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{"REMU 5%0",          OP_REMU,   32'd5,          32'd0,         32'd5};
        vecs[13] = '{"REM -5%0",          OP_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[14] = '{"DIV ovf",           OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[15] = '{"REM ovf",           OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[16] = '{"MUL 0*x",           OP_MUL,    32'd0,          32'd12345,     32'd0};
        vecs[17] = '{"DIVU max/1",        OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};

        bus.in_valid  = 1'b0;
        bus.funct3    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset result", bus.result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++)
            run_check(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Backpressure: result held, new request ignored until back in IDLE.
        bus.in_valid = 1'b1; bus.funct3 = OP_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        r0 = bus.result;
        check("bp first result", r0, 32'd81);
        bus.in_valid = 1'b1; bus.funct3 = OP_DIVU; bus.op_a = 32'd50; bus.op_b = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp out_valid held", {31'b0, bus.out_valid}, 32'd1);
            check("bp result held", bus.result, r0);
            check("bp in_ready low", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp idle after drain", {31'b0, bus.in_ready}, 32'd1);
        check("bp out_valid cleared", {31'b0, bus.out_valid}, 32'd0);
        check("bp result after drain", bus.result, r0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp second accepted", {31'b0, bus.in_ready}, 32'd0);
        wait_out(lat);
        check("bp second latency", 32'(lat), 32'd34);
        check("bp second result", bus.result, 32'd10);
        drain();

        // Flush at counter 15.
        bus.in_valid = 1'b1; bus.funct3 = OP_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("flush out_valid", {31'b0, bus.out_valid}, 32'd0);
        saw = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) saw = 1'b1; end
        check("flush no out_valid", {31'b0, saw}, 32'd0);
        check("flush result kept", bus.result, 32'd10);
        // A request in the same cycle as flush is dropped.
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush blocks accept", {31'b0, bus.in_ready}, 32'd1);
        run_check("after flush MULHU", OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0,
                  ref_result(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0));

        // Asynchronous reset mid-CALC.
        bus.in_valid = 1'b1; bus.funct3 = OP_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst mid in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst mid out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst mid result", bus.result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_check("after reset DIV", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = 32'd0;
                3: b = $urandom_range(1, 20);
                default: ;
            endcase
            run_check("random", f, a, b, ref_result(f, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
